ysyx_23060203_div: RTL

Iterative RV32M divide unit computing DIV, DIVU, REM and REMU. It sits beside the combinational ALU in the execute stage. The ALU does single-cycle arithmetic, and this block does the multi-cycle divide that the ALU cannot. Operands enter and results leave over valid/ready handshakes, so the pipeline stalls only while a divide is in flight.

---
 rtl/ysyx_23060203_div_pkg.sv | 34 +++
 rtl/ysyx_23060203_div_step.sv | 25 ++
 rtl/ysyx_23060203_div.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_div_pkg.sv
// Shared execute-stage definitions: ALU op codes, divide funct encodings,
// divider FSM states and a small conditional-negate helper.
package ysyx_23060203_div_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // Bit 1 selects remainder, bit 0 selects unsigned.
   localparam logic [1:0] DIV_DIV  = 2'b00;
   localparam logic [1:0] DIV_DIVU = 2'b01;
   localparam logic [1:0] DIV_REM  = 2'b10;
   localparam logic [1:0] DIV_REMU = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } divState_e;

   function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] value, input logic neg);
      return neg ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/ysyx_23060203_div_step.sv
// One combinational restoring-division iteration on magnitudes.
module ysyx_23060203_DivStep
   import ysyx_23060203_div_pkg::*;
(
   input  logic [32:0]     rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [32:0]     rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [33:0] shifted;
   logic [33:0] trial;
   logic        trialNonNeg;

   // Subtract one bit wider than the remainder so the sign bit is never ambiguous.
   always_comb begin
      shifted     = {rem_i, quo_i[XLEN-1]};
      trial       = shifted - {2'b00, divisor_i};
      trialNonNeg = ~trial[33];
      rem_o       = trialNonNeg ? trial[32:0] : shifted[32:0];
      quo_o       = {quo_i[XLEN-2:0], trialNonNeg};
   end

endmodule

// File: rtl/ysyx_23060203_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with valid/ready handshakes,
// one restoring step per clock and early exit for divide-by-zero and overflow.
module ysyx_23060203_div
   import ysyx_23060203_div_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [1:0]      in_funct,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_val
);

   divState_e       state_q, state_d;
   logic [4:0]      count_q, count_d;
   logic [32:0]     rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [XLEN-1:0] outVal_q, outVal_d;
   logic            negQuo_q, negQuo_d;
   logic            negRem_q, negRem_d;
   logic            isRem_q, isRem_d;

   logic [32:0]     remStep;
   logic [XLEN-1:0] quoStep;
   logic            isSigned, divByZero, overflow;
   logic [XLEN-1:0] magA, magB;

   ysyx_23060203_DivStep u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (remStep),
      .quo_o     (quoStep)
   );

   always_comb begin
      isSigned  = ~in_funct[0];
      magA      = condNeg(in_a, isSigned & in_a[XLEN-1]);
      magB      = condNeg(in_b, isSigned & in_b[XLEN-1]);
      divByZero = (in_b == '0);
      overflow  = isSigned && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
   end

   // Special cases resolve straight to DONE; everything else runs 32 CALC steps.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      outVal_d  = outVal_q;
      negQuo_d  = negQuo_q;
      negRem_d  = negRem_q;
      isRem_d   = isRem_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  isRem_d = in_funct[1];
                  if (divByZero) begin
                     outVal_d = in_funct[1] ? in_a : 32'hFFFF_FFFF;
                     state_d  = S_DONE;
                  end else if (overflow) begin
                     outVal_d = in_funct[1] ? 32'h0000_0000 : 32'h8000_0000;
                     state_d  = S_DONE;
                  end else begin
                     rem_d     = '0;
                     quo_d     = magA;
                     divisor_d = magB;
                     negQuo_d  = isSigned & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                     negRem_d  = isSigned & in_a[XLEN-1];
                     count_d   = '0;
                     state_d   = S_CALC;
                  end
               end
            end
            S_CALC: begin
               rem_d   = remStep;
               quo_d   = quoStep;
               count_d = count_q + 5'd1;
               if (count_q == 5'd31) begin
                  outVal_d = isRem_q
                     ? condNeg(remStep[XLEN-1:0], negRem_q && (remStep[XLEN-1:0] != '0))
                     : condNeg(quoStep, negQuo_q && (quoStep != '0));
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         outVal_q  <= '0;
         negQuo_q  <= 1'b0;
         negRem_q  <= 1'b0;
         isRem_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         outVal_q  <= outVal_d;
         negQuo_q  <= negQuo_d;
         negRem_q  <= negRem_d;
         isRem_q   <= isRem_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_val   = outVal_q;

endmodule
